// File: rtl/arbutterfly_puf_axi_slave.sv
// AXI4-Lite register front end that runs an arbiter/butterfly PUF through repeated
// excite/settle/sample rounds and tallies the responses for software readback.
module arbutterfly_puf_axi_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int CHAL_WIDTH         = 32,
   parameter int SETTLE_CYCLES      = 16
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic [CHAL_WIDTH-1:0]           puf_challenge,
   output logic                            puf_excite,
   input  logic                            puf_response
);

   localparam int SW = $clog2(SETTLE_CYCLES);

   typedef enum logic [2:0] {IDLE, EXCITE, SETTLE, SAMPLE, FINISH} state_t;

   state_t                state, state_next;
   logic                  aw_rdy, ar_rdy, b_vld, r_vld;
   logic [31:0]           r_data;
   logic [7:0]            nsamp_cfg, target, nsamp_new;
   logic [CHAL_WIDTH-1:0] chal;
   logic [15:0]           ones, samples;
   logic                  done, majority;
   logic [1:0]            sync;
   logic [SW-1:0]         settle_cnt;
   logic                  wr_en, rd_en, start, busy, last_sample;
   logic [1:0]            wr_sel, rd_sel;
   logic [31:0]           chal_word, chal_merge, rd_word;
   logic                  unused;

   assign wr_en  = aw_rdy && s_axi_awvalid && s_axi_wvalid;
   assign rd_en  = ar_rdy && s_axi_arvalid;
   assign wr_sel = s_axi_awaddr[3:2];
   assign rd_sel = s_axi_araddr[3:2];
   assign busy   = (state != IDLE);
   assign start  = wr_en && (wr_sel == 2'd0) && s_axi_wstrb[0] && s_axi_wdata[0] && !busy;
   assign nsamp_new   = s_axi_wstrb[1] ? s_axi_wdata[15:8] : nsamp_cfg;
   assign last_sample = ((samples + 16'd1) == {8'd0, target});
   assign chal_word   = 32'(chal);

   assign s_axi_awready = aw_rdy;
   assign s_axi_wready  = aw_rdy;
   assign s_axi_bvalid  = b_vld;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = ar_rdy;
   assign s_axi_rvalid  = r_vld;
   assign s_axi_rdata   = r_data;
   assign s_axi_rresp   = 2'b00;
   assign puf_challenge = chal;
   assign puf_excite    = (state == EXCITE);
   assign unused        = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0], chal_merge};

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         chal_merge[8*b +: 8] = s_axi_wstrb[b] ? s_axi_wdata[8*b +: 8] : chal_word[8*b +: 8];
      end
   end

   always_comb begin
      rd_word = 32'd0;
      case (rd_sel)
         2'd0: rd_word = {16'd0, nsamp_cfg, 8'd0};
         2'd1: rd_word = chal_word;
         2'd2: rd_word = {samples, ones};
         2'd3: rd_word = {29'd0, majority, done, busy};
         default: rd_word = 32'd0;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = EXCITE;
         EXCITE:  state_next = SETTLE;
         SETTLE:  if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_next = SAMPLE;
         SAMPLE:  state_next = last_sample ? FINISH : EXCITE;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Ready strobes are registered so they are low in reset and pulse for exactly one cycle.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_rdy <= 1'b0;
         ar_rdy <= 1'b0;
         b_vld  <= 1'b0;
         r_vld  <= 1'b0;
         r_data <= 32'd0;
      end else begin
         aw_rdy <= !aw_rdy && s_axi_awvalid && s_axi_wvalid && !b_vld;
         ar_rdy <= !ar_rdy && s_axi_arvalid && !r_vld;
         if (wr_en)             b_vld <= 1'b1;
         else if (s_axi_bready) b_vld <= 1'b0;
         if (rd_en) begin
            r_vld  <= 1'b1;
            r_data <= rd_word;
         end else if (s_axi_rready) begin
            r_vld  <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= IDLE;
         nsamp_cfg  <= 8'd0;
         target     <= 8'd0;
         chal       <= '0;
         ones       <= 16'd0;
         samples    <= 16'd0;
         done       <= 1'b0;
         majority   <= 1'b0;
         sync       <= 2'b00;
         settle_cnt <= '0;
      end else begin
         state      <= state_next;
         sync       <= {sync[0], puf_response};
         settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
         if (wr_en && wr_sel == 2'd0 && s_axi_wstrb[1]) nsamp_cfg <= s_axi_wdata[15:8];
         if (wr_en && wr_sel == 2'd1 && !busy)          chal      <= chal_merge[CHAL_WIDTH-1:0];
         if (start) begin
            target   <= (nsamp_new == 8'd0) ? 8'd1 : nsamp_new;
            ones     <= 16'd0;
            samples  <= 16'd0;
            done     <= 1'b0;
            majority <= 1'b0;
         end
         if (state == SAMPLE) begin
            ones    <= ones + {15'd0, sync[1]};
            samples <= samples + 16'd1;
         end
         if (state == FINISH) begin
            done     <= 1'b1;
            majority <= ({ones, 1'b0} > {9'd0, target});
         end
      end
   end

endmodule

// File: tb/tb_arbutterfly_puf_axi_slave.sv
// Randomized self-checking bench for arbutterfly_puf_axi_slave against a
// cycle-window model of the register map and evaluation runs.
module tb_arbutterfly_puf_axi_slave;

   localparam int SETTLE = 16;
   localparam int PERIOD = SETTLE + 2;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [3:0]  s_axi_awaddr = '0;
   logic [2:0]  s_axi_awprot = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b1;
   logic [3:0]  s_axi_araddr = '0;
   logic [2:0]  s_axi_arprot = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b1;
   logic [31:0] puf_challenge;
   logic        puf_excite;
   logic        puf_response = 1'b0;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   logic [7:0]  m_nsamp = '0;
   logic [31:0] m_chal = '0;
   int run_start = -1, run_n = 0, exp_ones = 0, exc_cnt = 0, last_exc = 0;
   int resp_mode = 2;
   int wr_cyc = 0, rd_cyc = 0;

   arbutterfly_puf_axi_slave #(
      .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .CHAL_WIDTH(32), .SETTLE_CYCLES(SETTLE)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .puf_challenge(puf_challenge), .puf_excite(puf_excite), .puf_response(puf_response)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   // A fresh response bit is presented at every excite pulse; it is what that round samples.
   always @(negedge ACLK) begin
      if (ARESETN && puf_excite) begin
         puf_response = (resp_mode == 2) ? 1'($urandom_range(0, 1)) : (resp_mode == 1);
         exp_ones += int'(puf_response);
         exc_cnt++;
         last_exc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int run_end();
      return run_start + run_n * PERIOD + 1;
   endfunction

   function automatic bit busy_at(int e);
      return run_start >= 0 && e >= run_start && e < run_end();
   endfunction

   function automatic bit done_at(int e);
      return run_start >= 0 && e >= run_end();
   endfunction

   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int e);
      case (a[3:2])
         2'd0: begin
            if (s[1]) m_nsamp = d[15:8];
            if (s[0] && d[0] && !busy_at(e)) begin
               run_start = e + 1;
               run_n     = (m_nsamp == 0) ? 1 : int'(m_nsamp);
               exp_ones  = 0;
               exc_cnt   = 0;
            end
         end
         2'd1: if (!busy_at(e)) for (int b = 0; b < 4; b++) if (s[b]) m_chal[8*b +: 8] = d[8*b +: 8];
         default: ;
      endcase
   endtask

   task automatic model_read(input logic [1:0] sel, input int e, output logic [31:0] v, output logic [31:0] m);
      m = '1;
      v = '0;
      case (sel)
         2'd0: v = {16'h0, m_nsamp, 8'h0};
         2'd1: v = m_chal;
         2'd2: begin
            if (done_at(e)) v = {16'(run_n), 16'(exp_ones)};
            else if (busy_at(e)) m = '0;
         end
         default: begin
            v = {29'd0, done_at(e) && (2 * exp_ones > run_n), done_at(e), busy_at(e)};
            if (busy_at(e)) m = 32'h3;
         end
      endcase
   endtask

   task automatic write_req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      bit hs = 0, rdy;
      @(posedge ACLK); #1;
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      for (int k = 0; k < 20 && !hs; k++) begin
         @(negedge ACLK); rdy = s_axi_awready && s_axi_wready;
         @(posedge ACLK); hs = rdy;
      end
      #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      if (!hs) check("aw_handshake", 32'(hs), 1);
      else begin
         wr_cyc = cyc;
         model_write(a, d, s, wr_cyc - 1);
      end
   endtask

   task automatic write_resp();
      bit got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge ACLK); got = s_axi_bvalid;
      end
      if (!got) check("b_timeout", 32'(got), 1);
      else begin
         check("bresp", 32'(s_axi_bresp), 0);
         @(posedge ACLK); #1;
      end
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      s_axi_bready = 1'b1;
      write_req(a, d, s);
      write_resp();
   endtask

   task automatic axi_read(input logic [3:0] a, input int hold, input string tag);
      bit hs = 0, got = 0, rdy;
      logic [31:0] ev, em;
      @(posedge ACLK); #1;
      s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = (hold == 0);
      for (int k = 0; k < 20 && !hs; k++) begin
         @(negedge ACLK); rdy = s_axi_arready;
         @(posedge ACLK); hs = rdy;
      end
      #1;
      s_axi_arvalid = 1'b0;
      if (!hs) check({tag, "_ar_timeout"}, 32'(hs), 1);
      else begin
         rd_cyc = cyc;
         model_read(a[3:2], rd_cyc - 1, ev, em);
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge ACLK); got = s_axi_rvalid;
         end
         if (!got) check({tag, "_r_timeout"}, 32'(got), 1);
         else begin
            if (em != 0) check(tag, s_axi_rdata & em, ev & em);
            check({tag, "_rresp"}, 32'(s_axi_rresp), 0);
            for (int k = 0; k < hold; k++) begin
               @(negedge ACLK);
               check({tag, "_hold_vld"}, 32'(s_axi_rvalid), 1);
               if (em != 0) check({tag, "_hold_data"}, s_axi_rdata & em, ev & em);
            end
            s_axi_rready = 1'b1;
            @(posedge ACLK); #1;
         end
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(posedge ACLK);
      #1;
   endtask

   task automatic check_run(input string tag);
      check({tag, "_excites"}, 32'(exc_cnt), 32'(run_n));
      check({tag, "_last_excite"}, 32'(last_exc), 32'(run_start + (run_n - 1) * PERIOD));
   endtask

   task automatic read_all(input string tag);
      for (int a = 0; a < 4; a++) axi_read(4'(a * 4), 0, $sformatf("%s_rd%0d", tag, a * 4));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctl"}, 32'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, puf_excite}), 0);
      check({tag, "_rdata"}, s_axi_rdata, 0);
      check({tag, "_chal"}, puf_challenge, 0);
   endtask

   initial begin
      int op;
      logic [3:0] a;
      repeat (3) @(posedge ACLK);
      #1;
      check_idle_outputs("rst");
      @(negedge ACLK) ARESETN = 1'b1;

      // Single-sample run with NSAMPLES=0, then writes to every register including the RO ones.
      axi_write(4'h0, 32'd1, 4'hF);
      wait_until(run_end());
      check_run("plan");
      axi_write(4'h4, 32'd2, 4'hF);
      axi_write(4'h8, 32'd3, 4'hF);
      axi_write(4'hC, 32'd4, 4'hF);
      read_all("plan");

      // Eight samples of a constant 1, with status reads straddling completion.
      resp_mode = 1;
      axi_write(4'h0, 32'h0000_0801, 4'h3);
      wait_until(run_end() - 3);
      axi_read(4'hC, 0, "ones_st_edge");
      axi_read(4'hC, 0, "ones_st_after");
      wait_until(run_end());
      check_run("ones");
      axi_read(4'h8, 0, "ones_result");
      axi_read(4'hC, 0, "ones_status");

      // Eight samples of a constant 0; challenge write and restart during the run are dropped.
      resp_mode = 0;
      axi_write(4'h0, 32'h0000_0801, 4'h3);
      axi_write(4'h4, 32'h0000_FFFF, 4'hF);
      axi_write(4'h0, 32'h0000_0001, 4'h1);
      axi_read(4'h4, 0, "busy_chal");
      axi_read(4'hC, 0, "busy_status");
      check("busy_puf_chal", puf_challenge, m_chal);
      wait_until(run_end());
      check_run("zeros");
      axi_read(4'h8, 0, "zeros_result");
      axi_read(4'hC, 0, "zeros_status");

      // Stalled write response blocks the next write; the pending write then writes 0.
      s_axi_bready = 1'b0;
      write_req(4'h4, 32'h1234_5678, 4'hF);
      s_axi_awaddr = 4'h4; s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge ACLK);
         check("bhold", 32'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 32'b100);
      end
      s_axi_bready = 1'b1;
      write_resp();
      write_req(4'h4, 32'h0, 4'hF);
      write_resp();
      axi_write(4'h4, 32'hAABB_CCDD, 4'b0101);
      axi_read(4'h4, 10, "strb_hold");

      // Random register traffic interleaved with short random-response runs.
      resp_mode = 2;
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         a  = 4'($urandom_range(0, 3) * 4);
         case (op)
            0: axi_write(a, $urandom() & 32'hFFFF_FFFE, 4'($urandom_range(0, 15)));
            1: axi_read(a, $urandom_range(0, 3), $sformatf("rnd%0d_rd%0h", it, a));
            2: axi_write(4'h0, {16'h0, 8'($urandom_range(0, 6)), 8'h01}, 4'h3);
            default: if (run_start >= 0) begin
               wait_until(run_end());
               check_run($sformatf("rnd%0d", it));
               axi_read(4'h8, 0, $sformatf("rnd%0d_result", it));
            end
         endcase
         check($sformatf("rnd%0d_puf_chal", it), puf_challenge, m_chal);
      end

      // Asynchronous reset in the middle of a run.
      axi_write(4'h0, 32'h0000_0501, 4'h3);
      wait_until(run_start + 30);
      @(negedge ACLK); #2;
      ARESETN = 1'b0;
      #1;
      check_idle_outputs("midrst");
      run_start = -1; run_n = 0; m_nsamp = '0; m_chal = '0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK) ARESETN = 1'b1;
      #1;
      check("midrst_excite", 32'(puf_excite), 0);
      read_all("postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
